// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-port memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic REQ_IFETCH = 1'b0;
    localparam logic REQ_DATA   = 1'b1;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;
    localparam int LAT_CNT_W   = 2;

    // Terminal count of the WAIT counter; out-of-range latencies are clamped.
    function automatic logic [LAT_CNT_W-1:0] lat_last(input int lat);
        int c;
        c = lat;
        if (c < MEM_LAT_MIN) c = MEM_LAT_MIN;
        if (c > MEM_LAT_MAX) c = MEM_LAT_MAX;
        return LAT_CNT_W'(c - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way one-hot pick; ties go to the requester not granted
//               last, or always to requester 1 when MEM_ARB_DATA_PRIO_EN.
// Config      : MEM_ARB_DATA_PRIO_EN - fixed priority for requester 1
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

`ifdef MEM_ARB_DATA_PRIO_EN
    logic w_unused_last;
    assign w_unused_last = last;
`endif

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
`ifdef MEM_ARB_DATA_PRIO_EN
                grant = 2'b10;
`else
                grant = last ? 2'b01 : 2'b10;
`endif
            end
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates an instruction-fetch and a load/store port onto one
//               fixed-latency memory (IDLE -> ISSUE -> WAIT per access).
// Config      : MEM_ARB_DATA_PRIO_EN - requester 1 wins every tie
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_we,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_we,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [ADDR_W-1:0] memory_address,
    output logic [DATA_W-1:0] memory_data_out,
    output logic              memory_write_enable,
    input  logic [DATA_W-1:0] memory_data_in
);

    localparam logic [LAT_CNT_W-1:0] c_LAT_LAST  = lat_last(MEM_LAT);
    localparam logic [ADDR_W-1:0]    c_WORD_MASK = ~ADDR_W'(3);

    arb_state_t           r_state;
    logic                 r_last;
    logic                 r_id;
    logic                 r_we;
    logic [LAT_CNT_W-1:0] r_cnt;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_wdata;
    logic                 r_mem_we;
    logic                 r_rsp0_valid;
    logic                 r_rsp1_valid;
    logic [DATA_W-1:0]    r_rdata0;
    logic [DATA_W-1:0]    r_rdata1;

    logic [1:0]           w_grant;
    logic                 w_idle;
    logic                 w_accept;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic                 w_sel_we;
    logic [DATA_W-1:0]    w_capture;

    rr_arbiter2 u_rr_arbiter2 (
        .valid ({req1_valid, req0_valid}),
        .last  (r_last),
        .grant (w_grant)
    );

    // Ready is combinational so a request is accepted in the cycle it appears.
    assign w_idle   = (r_state == IDLE) && !reset;
    assign w_accept = w_idle && (w_grant != 2'b00);

    assign req0_ready = w_idle && w_grant[0];
    assign req1_ready = w_idle && w_grant[1];

    assign w_sel_addr  = w_grant[1] ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_grant[1] ? req1_wdata : req0_wdata;
    assign w_sel_we    = w_grant[1] ? req1_we    : req0_we;

    assign w_capture = r_we ? '0 : memory_data_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last       <= REQ_DATA;
            r_id         <= REQ_IFETCH;
            r_we         <= 1'b0;
            r_cnt        <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        // The memory-side registers double as the request latch.
                        r_id        <= w_grant[1];
                        r_last      <= w_grant[1];
                        r_we        <= w_sel_we;
                        r_mem_addr  <= w_sel_addr & c_WORD_MASK;
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_we    <= w_sel_we;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_mem_we <= 1'b0;
                    r_cnt    <= '0;
                    r_state  <= WAIT;
                end
                WAIT: begin
                    if (r_cnt == c_LAT_LAST) begin
                        if (r_id == REQ_DATA) begin
                            r_rsp1_valid <= 1'b1;
                            r_rdata1     <= w_capture;
                        end else begin
                            r_rsp0_valid <= 1'b1;
                            r_rdata0     <= w_capture;
                        end
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + LAT_CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp0_valid          = r_rsp0_valid;
    assign rsp1_valid          = r_rsp1_valid;
    assign rsp0_rdata          = r_rdata0;
    assign rsp1_rdata          = r_rdata1;
    assign memory_address      = r_mem_addr;
    assign memory_data_out     = r_mem_wdata;
    assign memory_write_enable = r_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed vector bench for mem_arbiter (MEM_LAT=1 and 4).
// Config      : MEM_ARB_DATA_PRIO_EN changes the expected tie winners
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int LAT = 1;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req0_valid, req1_valid, req0_we, req1_we;
    logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_rdata, rsp1_rdata, memory_address, memory_data_out, memory_data_in;
    logic        memory_write_enable;

    logic        d4_v0, d4_we0, d4_v1, d4_we1;
    logic [31:0] d4_a0, d4_d0, d4_a1, d4_d1;
    logic        d4_rdy0, d4_rdy1, d4_rv0, d4_rv1, d4_mwe;
    logic [31:0] d4_rd0, d4_rd1, d4_maddr, d4_mdout, d4_mdin;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_we(req0_we), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_we(req1_we), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .memory_address(memory_address), .memory_data_out(memory_data_out),
        .memory_write_enable(memory_write_enable), .memory_data_in(memory_data_in)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) dut4 (
        .clk(clk), .reset(reset),
        .req0_valid(d4_v0), .req0_addr(d4_a0), .req0_wdata(d4_d0),
        .req0_we(d4_we0), .req0_ready(d4_rdy0),
        .req1_valid(d4_v1), .req1_addr(d4_a1), .req1_wdata(d4_d1),
        .req1_we(d4_we1), .req1_ready(d4_rdy1),
        .rsp0_valid(d4_rv0), .rsp0_rdata(d4_rd0),
        .rsp1_valid(d4_rv1), .rsp1_rdata(d4_rd1),
        .memory_address(d4_maddr), .memory_data_out(d4_mdout),
        .memory_write_enable(d4_mwe), .memory_data_in(d4_mdin)
    );

    typedef struct {
        logic        v0, v1, we0, we1;
        logic [31:0] a0, a1, d0, d1, mem;
        logic        win;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] exp_rd[2];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v0, v1, we0, we1,
                                input logic [31:0] a0, a1, d0, d1, mem,
                                input logic win);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.we0 = we0; v.we1 = we1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.mem = mem; v.win = win;
        return v;
    endfunction

    task automatic chk_cleared(input string tag);
        chk({tag, "_ready0"}, req0_ready, 0);
        chk({tag, "_ready1"}, req1_ready, 0);
        chk({tag, "_rsp0v"}, rsp0_valid, 0);
        chk({tag, "_rsp1v"}, rsp1_valid, 0);
        chk({tag, "_mwe"}, memory_write_enable, 0);
        chk({tag, "_maddr"}, memory_address, 0);
        chk({tag, "_mdout"}, memory_data_out, 0);
        chk({tag, "_rdata0"}, rsp0_rdata, 0);
        chk({tag, "_rdata1"}, rsp1_rdata, 0);
    endtask

    // One complete access: grant, issue, wait, response.
    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] ea, ed, erd;
        logic        ewe;
        string       t;
        t   = $sformatf("v%0d", idx);
        ea  = (v.win ? v.a1 : v.a0) & 32'hFFFF_FFFC;
        ed  = v.win ? v.d1 : v.d0;
        ewe = v.win ? v.we1 : v.we0;
        erd = ewe ? 32'h0 : v.mem;
        @(negedge clk);
        req0_valid = v.v0; req0_addr = v.a0; req0_wdata = v.d0; req0_we = v.we0;
        req1_valid = v.v1; req1_addr = v.a1; req1_wdata = v.d1; req1_we = v.we1;
        memory_data_in = JUNK;
        #1;
        chk({t, "_ready0"}, req0_ready, !v.win);
        chk({t, "_ready1"}, req1_ready, v.win);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        req0_addr = ~v.a0; req1_addr = ~v.a1; req0_wdata = ~v.d0; req1_wdata = ~v.d1;
        req0_we = ~v.we0; req1_we = ~v.we1;
        #1;
        chk({t, "_issue_addr"}, memory_address, ea);
        chk({t, "_issue_we"}, memory_write_enable, ewe);
        if (ewe) chk({t, "_issue_wdata"}, memory_data_out, ed);
        chk({t, "_issue_ready"}, {req1_ready, req0_ready}, 0);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            memory_data_in = (k == LAT) ? v.mem : JUNK;
            #1;
            chk({t, "_wait_mwe"}, memory_write_enable, 0);
            chk({t, "_wait_rsp"}, {rsp1_valid, rsp0_valid}, 0);
        end
        @(negedge clk);
        memory_data_in = JUNK;
        #1;
        exp_rd[v.win] = erd;
        chk({t, "_rsp0v"}, rsp0_valid, !v.win);
        chk({t, "_rsp1v"}, rsp1_valid, v.win);
        chk({t, "_rdata0"}, rsp0_rdata, exp_rd[0]);
        chk({t, "_rdata1"}, rsp1_rdata, exp_rd[1]);
        chk({t, "_hold_addr"}, memory_address, ea);
        chk({t, "_idle_mwe"}, memory_write_enable, 0);
    endtask

    initial begin
        logic w_tie;
`ifdef MEM_ARB_DATA_PRIO_EN
        w_tie = 1'b1;
`else
        w_tie = 1'b0;
`endif
        vecs[0] = mk(1, 0, 0, 0, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF, 0);
        vecs[1] = mk(1, 1, 0, 1, 32'h104, 32'h203, 0, 32'h1234_5678, 32'h5A5A_5A5A, 1);
        vecs[2] = mk(1, 1, 0, 0, 32'h008, 32'h30C, 0, 0, 32'hCAFE_F00D, w_tie);
        vecs[3] = mk(1, 1, 1, 0, 32'h040, 32'h055, 32'h11, 0, 32'h77, 1);
        vecs[4] = mk(0, 1, 0, 0, 32'h0, 32'h1002, 0, 0, 32'hA5A5_A5A5, 1);
        vecs[5] = mk(1, 0, 1, 0, 32'hFFFF_FFFF, 32'h0, 32'hFEED_FACE, 0, 32'h3333_3333, 0);
        vecs[6] = mk(1, 1, 0, 0, 32'h007, 32'h800, 0, 0, 32'h0BAD_F00D, 1);
        exp_rd[0] = 0; exp_rd[1] = 0;

        reset = 1;
        req0_valid = 1; req1_valid = 1; req0_we = 1; req1_we = 1;
        req0_addr = 32'h44; req1_addr = 32'h88; req0_wdata = 32'h1; req1_wdata = 32'h2;
        memory_data_in = JUNK;
        d4_v0 = 0; d4_v1 = 0; d4_we0 = 0; d4_we1 = 0;
        d4_a0 = 0; d4_a1 = 0; d4_d0 = 0; d4_d1 = 0; d4_mdin = JUNK;

        repeat (2) @(negedge clk);
        #1;
        chk_cleared("reset");
        reset = 0;
        req0_valid = 0; req1_valid = 0;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset during the final WAIT cycle must abort without a response.
        @(negedge clk);
        req0_valid = 1; req0_addr = 32'h500; req0_we = 0;
        #1;
        chk("abort_grant", req0_ready, 1);
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        memory_data_in = 32'h5555_5555;
        reset = 1;
        @(negedge clk);
        req0_valid = 1; req1_valid = 1; req0_we = 1; req1_we = 1;
        req0_addr = 32'h600; req1_addr = 32'h700;
        #1;
        chk_cleared("abort");
        // Last-grant pointer returns to 1, so the first tie goes to requester 0.
        reset = 0;
        #1;
        chk("post_reset_ready0", req0_ready, !w_tie);
        chk("post_reset_ready1", req1_ready, w_tie);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        #1;
        chk("issue_we", memory_write_enable, 1);
        chk("issue_addr", memory_address, w_tie ? 32'h700 : 32'h600);
        reset = 1;
        @(negedge clk);
        #1;
        chk("issue_abort_mwe", memory_write_enable, 0);
        chk("issue_abort_addr", memory_address, 0);
        reset = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("post_abort_rsp", {rsp1_valid, rsp0_valid}, 0);
        end

        // MEM_LAT=4 back-to-back reads: grants at 0, 6, 12; responses at 6, 12.
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            d4_v0 = 1;
            d4_a0 = (c < 6) ? 32'h100 : 32'h200;
            d4_mdin = (c == 5) ? 32'h1111_AAAA : (c == 11) ? 32'h2222_BBBB : JUNK;
            #1;
            chk($sformatf("lat4_ready_c%0d", c), d4_rdy0, (c % 6) == 0);
            chk($sformatf("lat4_rsp_c%0d", c), d4_rv0, (c == 6) || (c == 12));
            if (c == 1) chk("lat4_addr1", d4_maddr, 32'h100);
            if (c == 7) chk("lat4_addr2", d4_maddr, 32'h200);
            if (c == 6) chk("lat4_rdata1", d4_rd0, 32'h1111_AAAA);
            if (c == 12) chk("lat4_rdata2", d4_rd0, 32'h2222_BBBB);
        end
        d4_v0 = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width in bits.
REQ-002 Parameter DATA_W, default 32, memory data width in bits.
REQ-003 Parameter MEM_LAT, default 1, range 1..4: cycles from issue to valid memory_data_in.
REQ-004 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 Port reset, input, 1: reset, synchronous and active-high.
REQ-006 Ports req0_valid / req1_valid, input, 1: requester 0 (instruction fetch) / requester 1 (load/store) has a pending access.
REQ-007 Ports req0_addr / req1_addr, input, ADDR_W: byte address.
REQ-008 Ports req0_wdata / req1_wdata, input, DATA_W: store data.
REQ-009 Ports req0_we / req1_we, input, 1: access is a write.
REQ-010 Ports req0_ready / req1_ready, output, 1: grant; a request is accepted in a cycle where valid and ready are both high.
REQ-011 Ports rsp0_valid / rsp1_valid, output, 1: one-cycle completion pulse.
REQ-012 Ports rsp0_rdata / rsp1_rdata, output, DATA_W: read data; 0 for writes.
REQ-013 Port memory_address, output, ADDR_W: shared memory address.
REQ-014 Port memory_data_out, output, DATA_W: shared memory write data.
REQ-015 Port memory_write_enable, output, 1: shared memory write strobe.
REQ-016 Port memory_data_in, input, DATA_W: shared memory read data.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT.
REQ-018 In IDLE with at least one valid request, the block SHALL assert ready combinationally to exactly one winner, latch its addr/wdata/we/id, and go to ISSUE.
REQ-019 Round-robin SHALL apply: when both requesters are valid, the winner is the requester not granted last; the last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-020 In ISSUE, the block SHALL drive the latched address (bits [1:0] forced to 0), wdata and we for exactly one cycle, then go to WAIT.
REQ-021 In WAIT, a counter SHALL run MEM_LAT cycles; on the final cycle the block SHALL capture memory_data_in (writes capture 0) and return to IDLE.
REQ-022 rsp<id>_valid SHALL pulse high for one cycle, MEM_LAT+2 cycles after the grant cycle, with rsp<id>_rdata holding the captured value until the next response to that port.
REQ-023 The cycle in which rsp_valid is high SHALL be an IDLE cycle, so a new grant may coincide with it; maximum throughput is one access per MEM_LAT+2 cycles.
REQ-024 Outside ISSUE, memory_write_enable SHALL be 0; memory_address and memory_data_out SHALL hold their last driven values.
REQ-025 Both ready outputs SHALL be 0 in ISSUE and WAIT.
REQ-026 A requester SHALL hold its inputs stable only in the accept cycle; later changes SHALL NOT affect the access in flight.

Reset
REQ-027 While reset is high, the block SHALL force the state to IDLE, both ready and rsp_valid outputs to 0, memory_write_enable to 0, memory_address and memory_data_out to 0, both rdata registers to 0, and the last-grant pointer to 1.
REQ-028 Reset asserted in ISSUE or WAIT SHALL abort the access with no rsp_valid pulse; memory_write_enable SHALL be 0 from the cycle after the reset edge.

Configuration
REQ-029 Macro MEM_ARB_DATA_PRIO_EN: when defined, requester 1 SHALL always win ties (fixed priority); when undefined, the round-robin of REQ-019 SHALL apply.

Structure
REQ-030 Package mem_arb_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT), the requester-id constants (REQ_IFETCH=0, REQ_DATA=1) and the MEM_LAT bound.
REQ-031 The two-way pick logic SHALL be a sub-module rr_arbiter2 with inputs valid[1:0] and last, and output one-hot grant[1:0].

Verification
REQ-032 Only req0 valid, addr 0x100, memory returns 0xDEADBEEF, MEM_LAT=1 -> req0_ready at t0, memory_address=0x100 at t1, rsp0_valid with 0xDEADBEEF at t3.
REQ-033 Both requesters valid every cycle -> grants alternate 0,1,0,1 (round-robin); with MEM_ARB_DATA_PRIO_EN defined -> grants are 1,1,1,1.
REQ-034 req1 write, addr 0x203, wdata 0x12345678 -> memory_address=0x200 and memory_write_enable high for exactly one cycle, then rsp1_valid with rdata 0.
REQ-035 Reset pulsed while in WAIT -> no rsp_valid, state IDLE, all outputs 0 on the following cycle.
REQ-036 MEM_LAT=4, back-to-back req0 reads -> accepts 6 cycles apart, each rsp_valid 6 cycles after its grant, with the second grant in the same cycle as the first rsp0_valid.
